// File: rtl/sdp_bram_fifo_reader.sv
// sdp_bram_fifo_reader: FIFO over a simple-dual-port block RAM, drained through a
// 2-entry prefetch buffer that hides the registered read latency.
module sdp_bram_fifo_reader #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic [ADDR_BITS:0]   count
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(DEPTH);

    logic [DATA_BITS-1:0] ram [DEPTH];
    logic [DATA_BITS-1:0] ram_q, slot0, slot1;
    logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic [ADDR_BITS:0]   ram_cnt;
    logic                 inflight;
    logic [1:0]           obuf_cnt, pos;
    logic                 push, pop, rd_en, cap;

    assign count     = ram_cnt + (ADDR_BITS+1)'(inflight) + (ADDR_BITS+1)'(obuf_cnt);
    assign in_ready  = count < DEPTH_C;
    assign out_valid = obuf_cnt != 2'd0;
    assign out_data  = slot0;
    assign push      = in_valid && in_ready && !clr;
    assign pop       = out_valid && out_ready && !clr;
    // pos is the buffer slot a returning read lands in after this cycle's pop
    assign pos       = obuf_cnt - {1'b0, pop};
    assign rd_en     = !clr && (ram_cnt != '0) && (({1'b0, pos} + {2'b0, inflight}) < 3'd2);
    assign cap       = inflight && !clr;

    always_ff @(posedge clk) begin
        if (push) ram[wr_ptr] <= in_data;
        if (rd_en) ram_q <= ram[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            obuf_cnt <= 2'd0;
            slot0    <= '0;
            slot1    <= '0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            obuf_cnt <= 2'd0;
        end else begin
            wr_ptr   <= wr_ptr + ADDR_BITS'(push);
            rd_ptr   <= rd_ptr + ADDR_BITS'(rd_en);
            ram_cnt  <= ram_cnt + (ADDR_BITS+1)'(push) - (ADDR_BITS+1)'(rd_en);
            inflight <= rd_en;
            obuf_cnt <= pos + 2'(cap);
            slot0    <= (cap && pos == 2'd0) ? ram_q : pop ? slot1 : slot0;
            if (cap && pos == 2'd1) slot1 <= ram_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (({1'b0, obuf_cnt} + {2'b0, inflight}) <= 3'd2);
            assert (count <= DEPTH_C);
            assert (ram_cnt <= DEPTH_C);
            assert (!(cap && pos == 2'd2));
        end
    end
endmodule

// File: tb/tb_sdp_bram_fifo_reader.sv
// tb_sdp_bram_fifo_reader: directed and random stimulus checked against a queue
// model where an entry becomes visible at the head 3 cycles after its push.
module tb_sdp_bram_fifo_reader;
    logic       clk = 1'b0;
    logic       rst_n, clr, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [4:0] count;
    int         checks = 0;
    int         failures = 0;

    sdp_bram_fifo_reader #(.ADDR_BITS(4), .DATA_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         t;
    } item_t;
    item_t q[$];
    int    cyc = 0;
    logic  m_pu, m_po;

    function automatic bit vis();
        return q.size() != 0 && q[0].t + 3 <= cyc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q.delete();
        else begin
            m_pu = in_valid && q.size() < 16 && !clr;
            m_po = vis() && out_ready && !clr;
            if (clr) q.delete();
            else begin
                if (m_po) void'(q.pop_front());
                if (m_pu) q.push_back('{in_data, cyc});
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_in_ready", 32'(in_ready), 32'(q.size() < 16));
            chk("m_out_valid", 32'(out_valid), 32'(vis()));
            if (vis()) chk("m_out_data", 32'(out_data), 32'(q[0].d));
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            step;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain;
        in_valid  = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && count != 0; c++) step;
        @(negedge clk);
        chk("drain_empty", 32'(count), 32'd0);
        step;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, pops;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        #2 rst_n = 1'b1;
        step;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        step;

        // single word latency
        in_valid = 1'b1; in_data = 8'h11;
        step;
        in_valid = 1'b0;
        @(negedge clk); chk("lat_t1", 32'(out_valid), 32'd0);
        step; @(negedge clk); chk("lat_t2", 32'(out_valid), 32'd0);
        step; @(negedge clk);
        chk("lat_t3_valid", 32'(out_valid), 32'd1);
        chk("lat_t3_data", 32'(out_data), 32'h11);
        chk("lat_t3_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        @(negedge clk);
        chk("lat_pop_valid", 32'(out_valid), 32'd0);
        chk("lat_pop_count", 32'(count), 32'd0);
        step;

        // fill to capacity, then drain in order
        fill(16, 8'h00);
        @(negedge clk);
        chk("full_count", 32'(count), 32'd16);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step;
        out_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 40 && idx < 16; c++) begin
            @(negedge clk);
            if (c == 0) chk("first_pop_in_ready", 32'(in_ready), 32'd0);
            if (c == 1) chk("after_pop_in_ready", 32'(in_ready), 32'd1);
            if (out_valid) begin
                chk("order", 32'(out_data), 32'(idx));
                idx++;
            end
            step;
        end
        out_ready = 1'b0;
        chk("pop_all", 32'(idx), 32'd16);

        // streaming throughput
        in_valid = 1'b1; out_ready = 1'b1; pops = 0;
        for (int i = 0; i < 40; i++) begin
            in_data = 8'h20 + 8'(i);
            @(negedge clk);
            if (out_valid) pops++;
            if (i == 20) chk("stream_count", 32'(count), 32'd3);
            step;
        end
        in_valid = 1'b0;
        chk("stream_pops", 32'(pops), 32'd37);
        drain;

        // full with simultaneous push and pop
        fill(16, 8'h40);
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
        @(negedge clk);
        chk("fullpp_in_ready", 32'(in_ready), 32'd0);
        chk("fullpp_out_valid", 32'(out_valid), 32'd1);
        step;
        out_ready = 1'b0;
        @(negedge clk);
        chk("fullpp_count15", 32'(count), 32'd15);
        chk("fullpp_ready1", 32'(in_ready), 32'd1);
        step;
        in_valid = 1'b0;
        @(negedge clk);
        chk("fullpp_count16", 32'(count), 32'd16);
        drain;

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            in_valid  = 1'($urandom_range(1));
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(1));
            clr       = ($urandom_range(99) == 0);
            step;
        end
        clr = 1'b0;
        drain;

        // flush with a read in flight
        fill(8, 8'h60);
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        @(negedge clk);
        chk("clr_pre_count", 32'(count), 32'd7);
        clr = 1'b1;
        step;
        clr = 1'b0;
        @(negedge clk);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_data = 8'hAB;
        step;
        in_valid = 1'b0;
        step; step;
        @(negedge clk);
        chk("clr_ab_valid", 32'(out_valid), 32'd1);
        chk("clr_ab_data", 32'(out_data), 32'hAB);
        chk("clr_ab_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        @(negedge clk);
        chk("clr_ab_gone", 32'(count), 32'd0);
        step;

        // async reset mid-stream
        fill(5, 8'h70);
        in_valid = 1'b1; in_data = 8'h77;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        step;
        @(negedge clk);
        chk("arst_after_count", 32'(count), 32'd0);
        chk("arst_after_valid", 32'(out_valid), 32'd0);
        step;
        in_valid = 1'b1; in_data = 8'h99;
        step;
        in_valid = 1'b0;
        step; step;
        @(negedge clk);
        chk("arst_push_data", 32'(out_data), 32'h99);
        step;
        drain;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdp_bram_fifo_reader.md
Name: sdp_bram_fifo_reader

Overview:
- Synchronous FIFO that drains a simple-dual-port block-RAM array (write port A, registered 1-cycle read port B) into a valid/ready stream. Used as the NoC router input-buffer front end.
- Owns the RAM write side, schedules the RAM reads, and hides read latency behind a 2-entry output prefetch buffer.
- Sustains one push and one pop per cycle.

Parameters:
- ADDR_BITS, 4, RAM address width; DEPTH = 2^ADDR_BITS is the total FIFO capacity (RAM + in-flight + output buffer).
- DATA_BITS, 8, flit/data width.

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush, active high.
- in_valid  in  1  producer has data.
- in_ready  out  1  FIFO can accept data.
- in_data  in  DATA_BITS  push data.
- out_valid  out  1  head of output buffer valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  DATA_BITS  head data, stable while out_valid && !out_ready.
- count  out  ADDR_BITS+1  total occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n=0, async):
  - wr_ptr=0, rd_ptr=0, ram_cnt=0, inflight=0, obuf_cnt=0.
  - out_valid=0, out_data=0, count=0, in_ready=1 (after deassert).
  - RAM contents are not reset.
- Push: fires when in_valid && in_ready. RAM[wr_ptr] <= in_data, then wr_ptr+1 (wraps mod DEPTH), ram_cnt+1.
- Pop: fires when out_valid && out_ready. The head leaves, the output buffer shifts, obuf_cnt-1.
- count = ram_cnt + inflight + obuf_cnt, all registered.
- in_ready = (count < DEPTH), from registered state only.
  - A pop in the same cycle does not free space for a push.
  - When full, in_ready=0 even if out_ready=1.
- Read issue, combinational in cycle k: rd_en = (ram_cnt != 0) && (obuf_cnt - pop + inflight < 2).
  - rd_en drives the RAM read enable with rd_ptr.
  - On rd_en: rd_ptr+1 (wraps), ram_cnt-1, inflight=1 next cycle; otherwise inflight=0.
  - ram_cnt next = ram_cnt + push - rd_en.
- Read-after-write hazard: a word written at the end of cycle t is readable no earlier than cycle t+1. The ram_cnt gating guarantees this. Same-address read-during-write is never relied on.
- Capture: when inflight=1, the registered RAM output is written into the output buffer at the end of that cycle.
  - It lands in slot obuf_cnt-pop.
  - Write and shift are simultaneous and must both be handled.
- Output buffer:
  - 2 registers: head = slot0.
  - out_valid = (obuf_cnt != 0).
  - out_data = slot0, updated only on pop or on capture into an empty buffer.
- Latency on an empty FIFO:
  - Push accepted in cycle t; read issued in cycle t+1; RAM data valid in cycle t+2.
  - out_valid=1 from cycle t+3.
- Throughput: with in_valid=1 and out_ready=1 held continuously, exactly one push and one pop per cycle in steady state, with no bubbles.
- Backpressure: out_ready=0 holds out_data/out_valid stable. Reads stop once obuf_cnt + inflight = 2.
- Invariants (assert):
  - obuf_cnt + inflight <= 2
  - count <= DEPTH
  - ram_cnt <= DEPTH
  - No capture when obuf_cnt - pop = 2.
- Wrap-around: pointers are ADDR_BITS wide and wrap naturally. Full/empty are decided by counters, never by pointer compare.
- clr=1, synchronous, highest priority:
  - Next cycle: wr_ptr=rd_ptr=ram_cnt=inflight=obuf_cnt=0.
  - A push or pop in the same cycle is discarded.
  - No RAM write or read enable is asserted that cycle.
  - out_valid=0 from the next cycle.
  - An in-flight read's data is dropped.
- Async reset mid-stream: all state clears immediately, and any partially pushed or in-flight data is lost.

Test Plan:
1. Reset, then push 0x11 in cycle 5 with out_ready=0 -> out_valid rises in cycle 8, out_data=0x11, count=1; raise out_ready -> pop in cycle 8, then out_valid=0 and count=0.
2. ADDR_BITS=4: push 16 words 0x00..0x0F with out_ready=0 -> in_ready=0 after the 16th, count=16. Then pop all -> order 0x00..0x0F, no duplicates, and in_ready returns the cycle after the first pop.
3. Continuous push (0x20, 0x21, ...) with out_ready=1 for 40 cycles -> after the 3-cycle fill, one pop per cycle in order, count steady at 3, pointers wrap twice, no bubbles.
4. Full FIFO with in_valid=1 and out_ready=1 in the same cycle -> pop accepted, push refused (in_ready=0); push accepted the next cycle, count returns to 16.
5. Random out_ready (50%) and random in_valid over 2000 cycles against a reference queue model -> data identical, invariants never violated, out_data stable while stalled.
6. Assert clr with 7 entries stored and 1 read in flight -> next cycle count=0 and out_valid=0; a subsequent push of 0xAB appears alone 3 cycles later. Repeat with rst_n pulsed low mid-stream -> same empty result immediately.
